// File: rtl/ps_config_pkg.sv
// ---------------------------------------------------------------------------
// ps_config_pkg
//
// Shared definitions for the passive-serial configuration master:
//   state_t   - sequencer states
//   ERR_*     - err_code values reported on the err_code output
//   max_int   - small elaboration-time helper for sizing counters
// ---------------------------------------------------------------------------
package ps_config_pkg;

    typedef enum logic [3:0] {
        IDLE,
        NCFG_LOW,
        WAIT_STATUS,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        TAIL,
        WAIT_INIT,
        DONE,
        ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE           = 2'b00;
    localparam logic [1:0] ERR_STATUS_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_STATUS_LOW     = 2'b10;
    localparam logic [1:0] ERR_CONF_TIMEOUT   = 2'b11;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ps_config_master_sync2.sv
// ---------------------------------------------------------------------------
// sync2
//
// Two-flop synchroniser for a single asynchronous input. Both flops reset to
// RST_VAL so the synchronised output reads as the input's inactive level
// while reset is applied and until the first real samples arrive.
//
// Ports:
//   clkin      in  system clock, rising edge
//   coldres_n  in  asynchronous active-low reset
//   d          in  asynchronous input
//   q          out synchronised copy of d (two clkin cycles of latency)
// ---------------------------------------------------------------------------
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clkin,
    input  logic coldres_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clkin or negedge coldres_n) begin
        if (!coldres_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ps_config_master.sv
// ---------------------------------------------------------------------------
// ps_config_master
//
// Autonomous passive-serial configuration sequencer for an ACEX1K FPGA.
// Pulses nCONFIG, waits for nSTATUS, serialises a byte stream LSB first on
// DATA0/DCLK, clocks extra DCLK pulses until CONF_DONE, then waits for
// INIT_DONE.
//
// Ports:
//   clkin      in   system clock, rising edge
//   coldres_n  in   asynchronous active-low reset
//   start      in   one-cycle pulse, honoured in IDLE / DONE / ERROR only
//   din        in   [7:0] config byte, shifted LSB first
//   din_valid  in   din is valid
//   din_last   in   marks the final byte (sampled with din_valid)
//   din_ready  out  byte accepted when din_valid && din_ready
//   config_n   out  FPGA nCONFIG
//   dclk       out  FPGA DCLK
//   data0      out  FPGA DATA0
//   status_n   in   FPGA nSTATUS (asynchronous)
//   conf_done  in   FPGA CONF_DONE (asynchronous)
//   init_done  in   FPGA INIT_DONE (asynchronous)
//   busy       out  high in every state except IDLE, DONE, ERROR
//   done       out  level, high in DONE
//   error      out  level, high in ERROR
//   err_code   out  [1:0] 00 none, 01 status timeout,
//                   10 status_n low while shifting, 11 conf_done/init timeout
//
// Byte handshake: a byte transfers on a rising clkin edge where
// din_valid && din_ready. din_ready is high only in LOAD and drops on the
// transfer edge, so exactly one byte is taken per LOAD visit; din_valid is
// ignored in every other state. Producers may hold din_valid high while
// waiting and must keep din/din_last stable until the transfer.
//
// All outputs are registers.
// ---------------------------------------------------------------------------
module ps_config_master
    import ps_config_pkg::*;
#(
    parameter int CLK_DIV        = 2,
    parameter int NCFG_CYCLES    = 16,
    parameter int STATUS_TIMEOUT = 4096,
    parameter int TAIL_CLKS      = 16,
    parameter int INIT_TIMEOUT   = 65535
) (
    input  logic       clkin,
    input  logic       coldres_n,
    input  logic       start,
    input  logic [7:0] din,
    input  logic       din_valid,
    input  logic       din_last,
    output logic       din_ready,
    output logic       config_n,
    output logic       dclk,
    output logic       data0,
    input  logic       status_n,
    input  logic       conf_done,
    input  logic       init_done,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code
);

    // Shared timeout counter covers the longest wait.
    localparam int CNT_MAX = max_int(max_int(NCFG_CYCLES, STATUS_TIMEOUT), INIT_TIMEOUT);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TAIL_W  = (TAIL_CLKS > 1) ? $clog2(TAIL_CLKS) : 1;

    localparam logic [CNT_W-1:0]  NCFG_LOAD   = CNT_W'(NCFG_CYCLES - 1);
    localparam logic [CNT_W-1:0]  STATUS_LOAD = CNT_W'(STATUS_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  INIT_LOAD   = CNT_W'(INIT_TIMEOUT - 1);
    localparam logic [DIV_W-1:0]  DIV_LOAD    = DIV_W'(CLK_DIV - 1);
    localparam logic [TAIL_W-1:0] TAIL_LAST   = TAIL_W'(TAIL_CLKS - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [TAIL_W-1:0] tail_cnt;
    logic              tail_hi;
    logic [1:0]        guard;
    logic [6:0]        shreg;      // remaining bits of the current byte
    logic [2:0]        bitcnt;
    logic              last_f;
    logic              seen_low;

    logic status_s;
    logic conf_s;
    logic init_s;
    logic shift_fault;

    sync2 #(.RST_VAL(1'b1)) u_sync_status (
        .clkin     (clkin),
        .coldres_n (coldres_n),
        .d         (status_n),
        .q         (status_s)
    );

    sync2 #(.RST_VAL(1'b0)) u_sync_conf (
        .clkin     (clkin),
        .coldres_n (coldres_n),
        .d         (conf_done),
        .q         (conf_s)
    );

    sync2 #(.RST_VAL(1'b0)) u_sync_init (
        .clkin     (clkin),
        .coldres_n (coldres_n),
        .d         (init_done),
        .q         (init_s)
    );

    // The FPGA pulling nSTATUS low while data is flowing means it rejected
    // the bitstream; this overrides every other action in those states.
    always_comb begin
        shift_fault = 1'b0;
        if (!status_s && (state == LOAD || state == SHIFT_LO || state == SHIFT_HI))
            shift_fault = 1'b1;
    end

    always_ff @(posedge clkin or negedge coldres_n) begin
        if (!coldres_n) begin
            state     <= IDLE;
            config_n  <= 1'b1;
            dclk      <= 1'b0;
            data0     <= 1'b0;
            din_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_code  <= ERR_NONE;
            cnt       <= '0;
            div_cnt   <= '0;
            tail_cnt  <= '0;
            tail_hi   <= 1'b0;
            guard     <= '0;
            shreg     <= '0;
            bitcnt    <= '0;
            last_f    <= 1'b0;
            seen_low  <= 1'b0;
        end else if (shift_fault) begin
            state     <= ERROR;
            error     <= 1'b1;
            err_code  <= ERR_STATUS_LOW;
            busy      <= 1'b0;
            dclk      <= 1'b0;
            din_ready <= 1'b0;
            config_n  <= 1'b1;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state     <= NCFG_LOW;
                        config_n  <= 1'b0;
                        cnt       <= NCFG_LOAD;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        err_code  <= ERR_NONE;
                        busy      <= 1'b1;
                        dclk      <= 1'b0;
                        data0     <= 1'b0;
                        din_ready <= 1'b0;
                        seen_low  <= 1'b0;
                    end
                end

                NCFG_LOW: begin
                    if (!status_s)
                        seen_low <= 1'b1;
                    if (cnt == '0) begin
                        config_n <= 1'b1;
                        cnt      <= STATUS_LOAD;
                        guard    <= 2'd2;
                        state    <= WAIT_STATUS;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                // The guard holds off both acceptance and the timeout for two
                // cycles after nCONFIG release, so a stale high nSTATUS still
                // in the synchroniser cannot be taken as "FPGA ready".
                WAIT_STATUS: begin
                    if (guard != 2'd0) begin
                        guard <= guard - 2'd1;
                    end else if (status_s && seen_low) begin
                        din_ready <= 1'b1;
                        state     <= LOAD;
                    end else if (cnt == '0) begin
                        state    <= ERROR;
                        error    <= 1'b1;
                        err_code <= ERR_STATUS_TIMEOUT;
                        busy     <= 1'b0;
                        config_n <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                LOAD: begin
                    if (din_valid && din_ready) begin
                        data0     <= din[0];
                        shreg     <= din[7:1];
                        last_f    <= din_last;
                        bitcnt    <= 3'd0;
                        din_ready <= 1'b0;
                        div_cnt   <= DIV_LOAD;
                        state     <= SHIFT_LO;
                    end
                end

                // data0 is already valid on entry; the low phase is its setup.
                SHIFT_LO: begin
                    if (div_cnt != '0) begin
                        div_cnt <= div_cnt - 1'b1;
                    end else begin
                        dclk    <= 1'b1;
                        div_cnt <= DIV_LOAD;
                        state   <= SHIFT_HI;
                    end
                end

                SHIFT_HI: begin
                    if (div_cnt != '0) begin
                        div_cnt <= div_cnt - 1'b1;
                    end else begin
                        dclk <= 1'b0;
                        if (bitcnt == 3'd7) begin
                            if (last_f) begin
                                data0    <= 1'b0;
                                div_cnt  <= DIV_LOAD;
                                tail_cnt <= '0;
                                tail_hi  <= 1'b0;
                                state    <= TAIL;
                            end else begin
                                din_ready <= 1'b1;
                                state     <= LOAD;
                            end
                        end else begin
                            bitcnt  <= bitcnt + 3'd1;
                            data0   <= shreg[0];
                            shreg   <= {1'b0, shreg[6:1]};
                            div_cnt <= DIV_LOAD;
                            state   <= SHIFT_LO;
                        end
                    end
                end

                // Free-running DCLK with DATA0 low; CONF_DONE is only examined
                // at the end of each complete pulse.
                TAIL: begin
                    data0 <= 1'b0;
                    if (div_cnt != '0) begin
                        div_cnt <= div_cnt - 1'b1;
                    end else if (!tail_hi) begin
                        dclk    <= 1'b1;
                        tail_hi <= 1'b1;
                        div_cnt <= DIV_LOAD;
                    end else begin
                        dclk    <= 1'b0;
                        tail_hi <= 1'b0;
                        div_cnt <= DIV_LOAD;
                        if (conf_s) begin
                            cnt   <= INIT_LOAD;
                            state <= WAIT_INIT;
                        end else if (tail_cnt == TAIL_LAST) begin
                            state    <= ERROR;
                            error    <= 1'b1;
                            err_code <= ERR_CONF_TIMEOUT;
                            busy     <= 1'b0;
                        end else begin
                            tail_cnt <= tail_cnt + 1'b1;
                        end
                    end
                end

                WAIT_INIT: begin
                    dclk <= 1'b0;
                    if (init_s) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (cnt == '0) begin
                        state    <= ERROR;
                        error    <= 1'b1;
                        err_code <= ERR_CONF_TIMEOUT;
                        busy     <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps_config_master.sv
module tb_ps_config_master;

    localparam int CLK_DIV        = 2;
    localparam int NCFG_CYCLES    = 16;
    localparam int STATUS_TIMEOUT = 4096;
    localparam int TAIL_CLKS      = 16;
    localparam int INIT_TIMEOUT   = 65535;

    // ---------------- clock / reset / DUT ----------------
    logic       clkin     = 1'b0;
    logic       coldres_n = 1'b0;
    logic       start     = 1'b0;
    logic [7:0] din       = 8'h00;
    logic       din_valid = 1'b0;
    logic       din_last  = 1'b0;
    logic       status_n  = 1'b1;
    logic       conf_done = 1'b0;
    logic       init_done = 1'b0;
    logic       din_ready, config_n, dclk, data0, busy, done, error;
    logic [1:0] err_code;

    always #5 clkin = ~clkin;

    ps_config_master #(
        .CLK_DIV        (CLK_DIV),
        .NCFG_CYCLES    (NCFG_CYCLES),
        .STATUS_TIMEOUT (STATUS_TIMEOUT),
        .TAIL_CLKS      (TAIL_CLKS),
        .INIT_TIMEOUT   (INIT_TIMEOUT)
    ) dut (
        .clkin     (clkin),
        .coldres_n (coldres_n),
        .start     (start),
        .din       (din),
        .din_valid (din_valid),
        .din_last  (din_last),
        .din_ready (din_ready),
        .config_n  (config_n),
        .dclk      (dclk),
        .data0     (data0),
        .status_n  (status_n),
        .conf_done (conf_done),
        .init_done (init_done),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_code  (err_code)
    );

    // ---------------- bookkeeping ----------------
    int         n_checks    = 0;
    int         n_fail      = 0;
    logic [0:0] exp_q[$];
    int         bits_popped = 0;
    int         tail_pulses = 0;
    logic       ready_seen  = 1'b0;
    logic       chk_timing  = 1'b1;

    // FPGA model controls
    logic status_rise_en   = 1'b1;
    logic conf_en          = 1'b1;
    logic force_status_low = 1'b0;

    // ---------------- FPGA model ----------------
    // nSTATUS low shortly after nCONFIG falls, high 10 cycles after release;
    // CONF_DONE after 16 data pulses + 3 tail pulses; INIT_DONE 20 cycles later.
    int   low_cnt = 0, rel_cnt = 0, rise_cnt = 0, init_cnt = 0;
    logic mdl_dclk_prev = 1'b0;

    always @(negedge clkin) begin
        if (config_n === 1'b0) begin
            rel_cnt   = 0;
            rise_cnt  = 0;
            init_cnt  = 0;
            conf_done = 1'b0;
            init_done = 1'b0;
            if (low_cnt < 2) low_cnt++;
            else status_n = 1'b0;
        end else begin
            low_cnt = 0;
            if (rel_cnt < 1000000) rel_cnt++;
            if (status_rise_en && rel_cnt == 10) status_n = 1'b1;
            if (dclk === 1'b1 && !mdl_dclk_prev) rise_cnt++;
            if (conf_en && rise_cnt >= 19 && dclk === 1'b0) conf_done = 1'b1;
            if (conf_done) begin
                if (init_cnt < 20) init_cnt++;
                if (init_cnt == 20) init_done = 1'b1;
            end
        end
        if (force_status_low) status_n = 1'b0;
        mdl_dclk_prev = (dclk === 1'b1);
    end

    // ---------------- scoreboard monitor ----------------
    logic       mon_prev = 1'b0;
    int         hi_len = 0, lo_len = 0;
    logic [0:0] exp_bit;

    always @(negedge clkin) begin
        if (!coldres_n) begin
            mon_prev = 1'b0;
            hi_len   = 0;
            lo_len   = 0;
        end else begin
            if (din_ready === 1'b1) ready_seen = 1'b1;
            if (dclk === 1'b1 && !mon_prev) begin
                if (exp_q.size() > 0) begin
                    exp_bit = exp_q.pop_front();
                    n_checks++;
                    if (data0 !== exp_bit[0]) begin
                        n_fail++;
                        $display("FAIL data0_bit%0d: got %b, expected %b", bits_popped, data0, exp_bit[0]);
                    end
                    if (chk_timing && (bits_popped % 8) != 0) begin
                        n_checks++;
                        if (lo_len != CLK_DIV) begin
                            n_fail++;
                            $display("FAIL dclk_low_len: got %0d cycles, expected %0d", lo_len, CLK_DIV);
                        end
                    end
                    bits_popped++;
                end else begin
                    tail_pulses++;
                    n_checks++;
                    if (data0 !== 1'b0) begin
                        n_fail++;
                        $display("FAIL tail_data0: got %b, expected 0", data0);
                    end
                    if (chk_timing) begin
                        n_checks++;
                        if (lo_len != CLK_DIV) begin
                            n_fail++;
                            $display("FAIL tail_low_len: got %0d cycles, expected %0d", lo_len, CLK_DIV);
                        end
                    end
                end
                hi_len = 1;
            end else if (dclk === 1'b1) begin
                hi_len++;
            end
            if (dclk === 1'b0 && mon_prev) begin
                if (chk_timing) begin
                    n_checks++;
                    if (hi_len != CLK_DIV) begin
                        n_fail++;
                        $display("FAIL dclk_high_len: got %0d cycles, expected %0d", hi_len, CLK_DIV);
                    end
                end
                lo_len = 1;
            end else if (dclk === 1'b0) begin
                lo_len++;
            end
            mon_prev = (dclk === 1'b1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(negedge clkin);
        start = 1'b1;
        @(negedge clkin);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input int stall);
        int n;
        int bad;
        n = 0;
        while (din_ready !== 1'b1 && n < 20000) begin
            @(negedge clkin);
            n++;
        end
        n_checks++;
        if (din_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL din_ready_wait: din_ready=%b after %0d cycles, expected 1", din_ready, n);
            return;
        end
        bad = 0;
        for (int i = 0; i < stall; i++) begin
            din = 8'($urandom_range(0, 255));
            if (din_ready !== 1'b1 || dclk !== 1'b0) bad++;
            @(negedge clkin);
        end
        if (stall > 0) begin
            n_checks++;
            if (bad != 0 || din_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL load_stall: %0d bad cycles (din_ready/dclk), expected 0", bad);
            end
        end
        din       = b;
        din_last  = last;
        din_valid = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
        @(negedge clkin);
        din_valid = 1'b0;
        din_last  = 1'b0;
        din       = 8'($urandom_range(0, 255));
        n_checks++;
        if (din_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL din_ready_drop: got %b, expected 0", din_ready);
        end
    endtask

    task automatic wait_end(output int cycles);
        cycles = 0;
        while (!(done === 1'b1 || error === 1'b1) && cycles < 20000) begin
            @(negedge clkin);
            cycles++;
        end
    endtask

    task automatic wait_config_release(output int n);
        n = 0;
        while (config_n === 1'b0 && n < 100) begin
            n++;
            @(negedge clkin);
        end
    endtask

    task automatic wait_bits(input int target);
        int n;
        n = 0;
        while (bits_popped < target && n < 500) begin
            @(negedge clkin);
            n++;
        end
        n_checks++;
        if (bits_popped < target) begin
            n_fail++;
            $display("FAIL wait_bits: got %0d bits, expected %0d", bits_popped, target);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        coldres_n = 1'b0;
        repeat (2) @(negedge clkin);
        n_checks++;
        if ({config_n, dclk, data0, din_ready, busy, done, error, err_code} !== 9'b1_000_000_00) begin
            n_fail++;
            $display("FAIL reset_values: got cfg=%b dclk=%b d0=%b rdy=%b busy=%b done=%b err=%b code=%b, expected 1 0 0 0 0 0 0 00",
                     config_n, dclk, data0, din_ready, busy, done, error, err_code);
        end
        coldres_n = 1'b1;
        repeat (3) @(negedge clkin);
        n_checks++;
        if (busy !== 1'b0 || config_n !== 1'b1 || din_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b config_n=%b din_ready=%b, expected 0 1 0", busy, config_n, din_ready);
        end
    endtask

    task automatic test_nominal(input int stall);
        int n;
        chk_timing     = 1'b1;
        status_rise_en = 1'b1;
        conf_en        = 1'b1;
        bits_popped    = 0;
        tail_pulses    = 0;
        exp_q.delete();
        pulse_start();
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL start_flags: busy=%b done=%b error=%b, expected 1 0 0", busy, done, error);
        end
        wait_config_release(n);
        n_checks++;
        if (n != NCFG_CYCLES) begin
            n_fail++;
            $display("FAIL config_n_low_len: got %0d cycles, expected %0d", n, NCFG_CYCLES);
        end
        send_byte(8'hA5, 1'b0, stall);
        pulse_start();  // must be ignored while shifting
        send_byte(8'h3C, 1'b1, 0);
        wait_end(n);
        n_checks++;
        if (done !== 1'b1 || error !== 1'b0 || err_code !== 2'b00 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL nominal_end: done=%b error=%b err_code=%b busy=%b after %0d cycles, expected 1 0 00 0",
                     done, error, err_code, busy, n);
        end
        n_checks++;
        if (bits_popped != 16 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL nominal_bits: got %0d shifted, %0d pending, expected 16 shifted, 0 pending", bits_popped, exp_q.size());
        end
        n_checks++;
        if (dclk !== 1'b0 || config_n !== 1'b1) begin
            n_fail++;
            $display("FAIL nominal_pins: dclk=%b config_n=%b, expected 0 1", dclk, config_n);
        end
    endtask

    task automatic test_load_stall();
        test_nominal(50);
    endtask

    task automatic test_status_timeout();
        int n;
        status_rise_en = 1'b0;
        pulse_start();
        ready_seen = 1'b0;
        wait_config_release(n);
        n = 0;
        while (error !== 1'b1 && n < 5000) begin
            @(negedge clkin);
            n++;
        end
        n_checks++;
        if (n != STATUS_TIMEOUT + 2) begin
            n_fail++;
            $display("FAIL status_timeout_len: got %0d cycles, expected %0d", n, STATUS_TIMEOUT + 2);
        end
        n_checks++;
        if (error !== 1'b1 || err_code !== 2'b01 || busy !== 1'b0 || config_n !== 1'b1) begin
            n_fail++;
            $display("FAIL status_timeout_flags: error=%b err_code=%b busy=%b config_n=%b, expected 1 01 0 1",
                     error, err_code, busy, config_n);
        end
        n_checks++;
        if (ready_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL status_timeout_ready: din_ready seen=%b, expected 0", ready_seen);
        end
        status_rise_en = 1'b1;
    endtask

    task automatic test_status_low_shift();
        int n;
        chk_timing  = 1'b1;
        bits_popped = 0;
        exp_q.delete();
        pulse_start();
        send_byte(8'hA5, 1'b0, 0);
        wait_bits(4);
        chk_timing       = 1'b0;
        force_status_low = 1'b1;
        n = 0;
        #1;
        while (status_n !== 1'b0 && n < 10) begin
            @(negedge clkin);
            #1;
            n++;
        end
        n = 0;
        while (error !== 1'b1 && n < 10) begin
            @(negedge clkin);
            n++;
        end
        n_checks++;
        if (error !== 1'b1 || n > 3) begin
            n_fail++;
            $display("FAIL status_low_latency: error=%b after %0d cycles, expected 1 within 3", error, n);
        end
        n_checks++;
        if (err_code !== 2'b10 || dclk !== 1'b0 || din_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL status_low_flags: err_code=%b dclk=%b din_ready=%b busy=%b, expected 10 0 0 0",
                     err_code, dclk, din_ready, busy);
        end
        force_status_low = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clkin);
    endtask

    task automatic test_tail_timeout();
        int n;
        chk_timing  = 1'b1;
        conf_en     = 1'b0;
        bits_popped = 0;
        tail_pulses = 0;
        exp_q.delete();
        pulse_start();
        send_byte(8'h5A, 1'b0, 0);
        send_byte(8'hC3, 1'b1, 0);
        wait_end(n);
        n_checks++;
        if (tail_pulses != TAIL_CLKS) begin
            n_fail++;
            $display("FAIL tail_pulses: got %0d, expected %0d", tail_pulses, TAIL_CLKS);
        end
        n_checks++;
        if (error !== 1'b1 || err_code !== 2'b11 || done !== 1'b0 || dclk !== 1'b0) begin
            n_fail++;
            $display("FAIL tail_timeout_flags: error=%b err_code=%b done=%b dclk=%b, expected 1 11 0 0",
                     error, err_code, done, dclk);
        end
        n_checks++;
        if (bits_popped != 16) begin
            n_fail++;
            $display("FAIL tail_bits: got %0d, expected 16", bits_popped);
        end
        conf_en = 1'b1;
    endtask

    task automatic test_reset_mid_shift();
        chk_timing  = 1'b1;
        bits_popped = 0;
        exp_q.delete();
        pulse_start();
        send_byte(8'h96, 1'b0, 0);
        wait_bits(3);
        @(posedge clkin);
        #3;
        coldres_n = 1'b0;
        #1;
        n_checks++;
        if ({config_n, dclk, data0, din_ready, busy, done, error, err_code} !== 9'b1_000_000_00) begin
            n_fail++;
            $display("FAIL reset_mid_shift: got cfg=%b dclk=%b d0=%b rdy=%b busy=%b done=%b err=%b code=%b, expected 1 0 0 0 0 0 0 00",
                     config_n, dclk, data0, din_ready, busy, done, error, err_code);
        end
        exp_q.delete();
        repeat (3) @(negedge clkin);
        coldres_n = 1'b1;
        @(negedge clkin);
        test_nominal(0);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_nominal(0);
        test_load_stall();
        test_status_timeout();
        test_status_low_shift();
        test_tail_timeout();
        test_reset_mid_shift();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps_config_master.md
Name: ps_config_master

Overview:
- Hardware sequencer that autonomously configures the ACEX1K FPGA in passive-serial mode from a byte stream.
- It is the initiating end of the nCONFIG / nSTATUS / CONF_DONE / INIT_DONE protocol, which the port-level CPLD logic otherwise exposes to Z80 software for bit-banging.
- Sits between a byte source (ROM reader or Z80 port FIFO) and the FPGA config pins.
- Drives config_n, dclk and data0, and reports busy/done/error.

Parameters:
- CLK_DIV, 2: clkin cycles per dclk half-period; must be ≥1.
- NCFG_CYCLES, 16: clkin cycles config_n is held low.
- STATUS_TIMEOUT, 4096: clkin cycles allowed for status_n to rise after config_n is released.
- TAIL_CLKS, 16: maximum extra dclk pulses after the last byte while waiting for conf_done.
- INIT_TIMEOUT, 65535: clkin cycles allowed for init_done after conf_done.

Ports:
- clkin  in  1  system clock, rising edge
- coldres_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins configuration; honoured only in IDLE, DONE or ERROR
- din  in  8  config byte, shifted LSB first
- din_valid  in  1  din is valid
- din_last  in  1  qualifies the final byte, sampled with din_valid
- din_ready  out  1  byte accepted on cycles where din_valid && din_ready
- config_n  out  1  FPGA nCONFIG
- dclk  out  1  FPGA DCLK
- data0  out  1  FPGA DATA0
- status_n  in  1  FPGA nSTATUS, asynchronous
- conf_done  in  1  FPGA CONF_DONE, asynchronous
- init_done  in  1  FPGA INIT_DONE, asynchronous
- busy  out  1  high in every state except IDLE, DONE and ERROR
- done  out  1  level; high in DONE
- error  out  1  level; high in ERROR
- err_code  out  2  00 none, 01 status timeout, 10 status_n low during shift, 11 conf_done/init timeout

Behaviour:
- Reset values: config_n=1, dclk=0, data0=0, din_ready=0, busy=0, done=0, error=0, err_code=00, state=IDLE.
- The reset is asynchronous and may arrive mid-operation.
- status_n, conf_done and init_done pass through 2-flop synchronisers; all decisions use the synchronised values.
- Every output is a register.
- IDLE/DONE/ERROR: on start, go to NCFG_LOW, clear done/error/err_code, set config_n=0, load the counter with NCFG_CYCLES-1.
- NCFG_LOW: count down; at 0 set config_n=1 and go to WAIT_STATUS with counter=STATUS_TIMEOUT-1.
  - Synchronised status_n must be observed low at least once during NCFG_LOW; if it is not, the failure is still caught in WAIT_STATUS, because status_n going high is not accepted before config_n release plus 2 cycles.
- WAIT_STATUS: synchronised status_n=1 goes to LOAD.
  - Counter reaching 0 first goes to ERROR with err_code=01, config_n=1.
- LOAD: din_ready=1.
  - On handshake: capture din into the shift register, capture din_last into last_f, set bitcnt=0, set data0=din[0], din_ready=0, go to SHIFT_LO.
  - din_ready drops the cycle after acceptance, so exactly one byte is taken per LOAD entry.
- SHIFT_LO: dclk=0 for CLK_DIV cycles (data setup), then dclk=1 and go to SHIFT_HI.
- SHIFT_HI: dclk=1 for CLK_DIV cycles, then dclk=0.
  - If bitcnt==7: go to TAIL if last_f, else to LOAD.
  - Otherwise: bitcnt+1, data0 takes the next bit, go to SHIFT_LO.
- status_n low during LOAD/SHIFT_LO/SHIFT_HI goes to ERROR with err_code=10, dclk=0, din_ready=0.
- TAIL: data0=0; keep toggling dclk at the same rate.
  - Synchronised conf_done=1 goes to WAIT_INIT; conf_done is checked after each full dclk pulse.
  - TAIL_CLKS full pulses without conf_done goes to ERROR with err_code=11.
  - conf_done rising earlier, during SHIFT, is ignored until TAIL.
- WAIT_INIT: dclk=0; counter=INIT_TIMEOUT-1.
  - Synchronised init_done=1 goes to DONE.
  - Timeout goes to ERROR with err_code=11.
- start outside IDLE/DONE/ERROR is ignored.
- din_valid outside LOAD is ignored.
- Counter width is clog2 of the largest timeout parameter; the counter saturates at 0.

Decomposition:
- Package ps_config_pkg holds the state enum (IDLE, NCFG_LOW, WAIT_STATUS, LOAD, SHIFT_LO, SHIFT_HI, TAIL, WAIT_INIT, DONE, ERROR) and the err_code constants.
- One sub-module, sync2, instantiated three times: a 2-flop synchroniser with its reset to the inactive level (status_n→1, conf_done→0, init_done→0).

Test Plan:
- Nominal, CLK_DIV=2, 2 bytes 0xA5, 0x3C (last), FPGA model raises status_n 10 cycles after config_n release and conf_done after 3 tail pulses, then init_done 20 cycles later -> config_n low 16 cycles; data0 serial 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 on dclk rising edges; dclk high/low 2 cycles each; done=1, err_code=00.
- status_n never rises -> error=1, err_code=01 exactly 4096+2 cycles after config_n release; din_ready never asserted.
- status_n forced low after the 4th bit of the first byte -> ERROR within 3 cycles, err_code=10, dclk=0, din_ready=0.
- conf_done never rises -> exactly 16 tail dclk pulses, then error=1, err_code=11.
- din_valid withheld for 50 cycles in LOAD -> dclk stays 0 and din_ready stays 1 throughout; shifting resumes correctly on valid.
- coldres_n pulsed low mid-SHIFT -> all outputs at reset values immediately; a subsequent start runs the full nominal sequence.
